answer_entry: RTL
=================

// Module: answer_entry
// PURPOSE
//  Parametrised answer-entry unit of the factorisation game.
//  - Player builds an N-digit answer on per-digit select buttons, while the game FSM's STATE is INPUT.
//  - Captures the current question and drives question/answer 7-seg nibbles.
//  - Commits the answer to the judge on DEC. Sits between the button debouncers/game FSM and the judge/display.
// PARAMETERS
//  N_DIGITS   3   answer digits (1..8)
//  Q_DIGITS   3   question digits shown; taken from QUESTION[Q_WIDTH-1 -: 4*Q_DIGITS]
//  Q_WIDTH    24  QUESTION bus width (>= 4*Q_DIGITS)
//  DIGIT_MIN  1   lowest selectable digit (>=1; 0 means "unset")
//  DIGIT_MAX  9   highest selectable digit (DIGIT_MIN..15)
// PORTS
//  CLK        in   1            system clock
//  RST        in   1            reset, asynchronous, active-high
//  STATE      in   4            game FSM state code (codes listed in the package)
//  QUESTION   in   Q_WIDTH      question from generator
//  SEL        in   N_DIGITS     per-digit increment buttons, level; bit i drives digit i
//  DEC        in   1            decide button, level
//  CLR        in   1            clear-answer button, level
//  SEG        out  4*N_DIGITS   answer display nibbles, digit i at [4i+:4]
//  SEG_Q      out  4*Q_DIGITS   question display nibbles
//  COUNT_OUT  out  4*N_DIGITS   committed answer to judge
//  ANS_VALID  out  1            1-cycle pulse: COUNT_OUT updated
//  QUE_OK     out  1            captured question is non-zero
//  LED        out  1            QUE_OK delayed one cycle
// BEHAVIOUR
//  - Reset: all registers and outputs are 0, including the edge-detect history.
//  - Button edges: SEL, DEC and CLR are edge-detected against a registered copy. Only a 0->1 edge acts; a held button does not repeat.
//  - q_r capture (1 cycle): q_r <= top 4*Q_DIGITS bits of QUESTION when any of these holds, else q_r <= 0:
//      (STATE==READY and QUESTION!=0), STATE==QUESTION, STATE==INPUT, STATE==WRONG.
//  - QUE_OK <= (q_r!=0): 2 cycles after QUESTION. LED <= QUE_OK: 3 cycles after QUESTION.
//  - SEG_Q <= q_r when STATE==QUESTION, else 0.
//  - SEG <= digit registers when STATE==INPUT, else 0.
//  - Digit update in STATE==INPUT, per digit i, independent:
//      rising CLR clears all digits to 0 and overrides every SEL edge that cycle;
//      else SEL[i] edge: 0 -> DIGIT_MIN, DIGIT_MAX -> DIGIT_MIN (wrap), otherwise +1.
//      Simultaneous SEL edges on different digits all take effect.
//  - Digits clear to 0 in DRAW, WRONG, GOOD, OUCH, WIN and LOSE. They hold in all other states.
//  - Commit, STATE==INPUT, rising DEC, all digits non-zero:
//      COUNT_OUT <= pre-update digit values (a SEL/CLR edge in the same cycle is not seen);
//      ANS_VALID pulses 1 cycle.
//      DEC with any digit 0 is ignored: no pulse, COUNT_OUT held.
//  - Outside INPUT, COUNT_OUT <= 0 and ANS_VALID = 0. Inside INPUT, COUNT_OUT holds between commits.
//  - Reset mid-entry: everything 0 immediately (async). Edge history resets to 0, so a button still held after reset release fires once.
// CONFIGURATION
//  - DIGIT_DOWN_EN defined:
//      extra input DOWN (1 bit, level); while DOWN==1 a SEL edge decrements:
//      0 -> DIGIT_MAX, DIGIT_MIN -> DIGIT_MAX, otherwise -1.
//  - Not defined: no DOWN port; increment only.
// STRUCTURE
//  - Package game_pkg:
//      4-bit state codes READY=0010, QUESTION=0011, INPUT=0100, DRAW=0110,
//        WRONG=0111, GOOD=1000, OUCH=1001, WIN=1010, LOSE=1011;
//      DIGIT_W=4; function is_clear_state(state).
//  - Sub-module digit_counter (MIN, MAX): one per digit, generate loop.
//      Inputs: inc, dec_dir, clr. Output: 4-bit value. Holds the wrap logic.
//  - Top holds edge detect, question path and commit.
// TESTING
//  1. RST high, then STATE=QUESTION, QUESTION=24'h123000:
//       SEG_Q=12'h123 2 cycles later; QUE_OK=1 at +2; LED=1 at +3.
//  2. STATE=INPUT, SEL[0] held 20 cycles:
//       digit0=1 (one step only); 9 more edges give 2..9 then 1.
//  3. Digits 4,5,6; DEC edge:
//       COUNT_OUT=12'h654, ANS_VALID high exactly 1 cycle.
//       With digit2=0, DEC gives no pulse.
//  4. SEL[1] edge and CLR edge in the same cycle:
//       all digits 0.
//     SEL[2] edge with DEC in the same cycle:
//       COUNT_OUT carries the old digit2.
//  5. Digits 3,3,3; STATE->WRONG:
//       digits 0 next cycle; SEG=0; COUNT_OUT=0; q_r still captured.
//  6. DIGIT_DOWN_EN defined, DOWN=1, SEL[0] edge from 0 (N_DIGITS=4, DIGIT_MAX=15):
//       digit0=15; next edge gives 14. Also async RST mid-entry zeroes all outputs.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the factorisation game: game FSM state codes, digit width
// and the helper that tells whether a state wipes the answer digits.
package game_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [3:0] {
    ST_READY    = 4'b0010,
    ST_QUESTION = 4'b0011,
    ST_INPUT    = 4'b0100,
    ST_DRAW     = 4'b0110,
    ST_WRONG    = 4'b0111,
    ST_GOOD     = 4'b1000,
    ST_OUCH     = 4'b1001,
    ST_WIN      = 4'b1010,
    ST_LOSE     = 4'b1011
  } state_e;

  // States in which an answer under construction is discarded
  function automatic logic is_clear_state(input logic [3:0] state);
    case (state)
      ST_DRAW, ST_WRONG, ST_GOOD, ST_OUCH, ST_WIN, ST_LOSE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/answer_entry_if.sv
// Button/question inputs and display/judge outputs of the answer-entry unit.
// DIGIT_DOWN_EN adds the DOWN direction input.
interface answer_entry_if
  import game_pkg::*;
#(
  parameter int unsigned N_DIGITS = 3,
  parameter int unsigned Q_DIGITS = 3,
  parameter int unsigned Q_WIDTH  = 24
);

  logic [3:0]                  STATE;
  logic [Q_WIDTH-1:0]          QUESTION;
  logic [N_DIGITS-1:0]         SEL;
  logic                        DEC;
  logic                        CLR;
`ifdef DIGIT_DOWN_EN
  logic                        DOWN;
`endif
  logic [DIGIT_W*N_DIGITS-1:0] SEG;
  logic [DIGIT_W*Q_DIGITS-1:0] SEG_Q;
  logic [DIGIT_W*N_DIGITS-1:0] COUNT_OUT;
  logic                        ANS_VALID;
  logic                        QUE_OK;
  logic                        LED;

  modport master (
    output STATE, QUESTION, SEL, DEC, CLR,
`ifdef DIGIT_DOWN_EN
    output DOWN,
`endif
    input  SEG, SEG_Q, COUNT_OUT, ANS_VALID, QUE_OK, LED
  );

  modport slave (
    input  STATE, QUESTION, SEL, DEC, CLR,
`ifdef DIGIT_DOWN_EN
    input  DOWN,
`endif
    output SEG, SEG_Q, COUNT_OUT, ANS_VALID, QUE_OK, LED
  );

endinterface

// File: rtl/answer_entry_digit_counter.sv
// One answer digit: 0 means unset, otherwise cycles MIN..MAX in either direction.
module digit_counter
  import game_pkg::*;
#(
  parameter int unsigned MIN = 1,
  parameter int unsigned MAX = 9
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               inc,
  input  logic               dec_dir,
  input  logic               clr,
  output logic [DIGIT_W-1:0] value
);

  localparam logic [DIGIT_W-1:0] V_MIN = DIGIT_W'(MIN);
  localparam logic [DIGIT_W-1:0] V_MAX = DIGIT_W'(MAX);

  logic [DIGIT_W-1:0] value_nxt;

  // Unset digits enter the range at the end the step direction points away from
  always_comb begin
    value_nxt = value;
    if (clr) begin
      value_nxt = '0;
    end else if (inc) begin
      if (dec_dir) begin
        value_nxt = (value == '0 || value == V_MIN) ? V_MAX : value - DIGIT_W'(1);
      end else begin
        value_nxt = (value == '0 || value == V_MAX) ? V_MIN : value + DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) value <= '0;
    else     value <= value_nxt;
  end

endmodule

// File: rtl/answer_entry.sv
// Answer-entry unit: button edge detect, question capture/display and answer commit.
// Build option DIGIT_DOWN_EN: DOWN input makes SEL edges decrement.
module answer_entry
  import game_pkg::*;
#(
  parameter int unsigned N_DIGITS  = 3,
  parameter int unsigned Q_DIGITS  = 3,
  parameter int unsigned Q_WIDTH   = 24,
  parameter int unsigned DIGIT_MIN = 1,
  parameter int unsigned DIGIT_MAX = 9
) (
  input  logic           CLK,
  input  logic           RST,
  answer_entry_if.slave  bus
);

  localparam int unsigned AW = DIGIT_W * N_DIGITS;
  localparam int unsigned QW = DIGIT_W * Q_DIGITS;

  logic [N_DIGITS-1:0]              sel_d;
  logic                             dec_d;
  logic                             clr_d;
  logic [N_DIGITS-1:0]              sel_rise;
  logic                             dec_rise;
  logic                             clr_rise;
  logic                             in_input;
  logic                             q_cap;
  logic                             all_set;
  logic                             clr_digits;
  logic                             dir_down;
  logic [N_DIGITS-1:0]              inc_vec;
  logic [N_DIGITS-1:0][DIGIT_W-1:0] digit;

  logic [QW-1:0] q_r;
  logic [QW-1:0] seg_q_r;
  logic [AW-1:0] seg_r;
  logic [AW-1:0] count_r;
  logic          valid_r;
  logic          que_ok_r;
  logic          led_r;

  assign sel_rise = bus.SEL & ~sel_d;
  assign dec_rise = bus.DEC & ~dec_d;
  assign clr_rise = bus.CLR & ~clr_d;
  assign in_input = (bus.STATE == ST_INPUT);

  assign q_cap = ((bus.STATE == ST_READY) && (bus.QUESTION != '0)) ||
                 (bus.STATE == ST_QUESTION) || in_input || (bus.STATE == ST_WRONG);

`ifdef DIGIT_DOWN_EN
  assign dir_down = bus.DOWN;
`else
  assign dir_down = 1'b0;
`endif

  // A CLR edge beats every SEL edge in the same cycle
  assign clr_digits = (in_input && clr_rise) || is_clear_state(bus.STATE);
  assign inc_vec    = (in_input && !clr_rise) ? sel_rise : '0;

  always_comb begin
    all_set = 1'b1;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (digit[i] == '0) all_set = 1'b0;
    end
  end

  for (genvar g = 0; g < int'(N_DIGITS); g++) begin : g_digit
    digit_counter #(
      .MIN (DIGIT_MIN),
      .MAX (DIGIT_MAX)
    ) u_digit (
      .CLK     (CLK),
      .RST     (RST),
      .inc     (inc_vec[g]),
      .dec_dir (dir_down),
      .clr     (clr_digits),
      .value   (digit[g])
    );
  end

  // Commit samples the digits before this cycle's SEL/CLR update lands
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sel_d    <= '0;
      dec_d    <= 1'b0;
      clr_d    <= 1'b0;
      q_r      <= '0;
      seg_q_r  <= '0;
      seg_r    <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      que_ok_r <= 1'b0;
      led_r    <= 1'b0;
    end else begin
      sel_d    <= bus.SEL;
      dec_d    <= bus.DEC;
      clr_d    <= bus.CLR;
      q_r      <= q_cap ? bus.QUESTION[Q_WIDTH-1 -: QW] : '0;
      que_ok_r <= (q_r != '0);
      led_r    <= que_ok_r;
      seg_q_r  <= (bus.STATE == ST_QUESTION) ? q_r : '0;
      seg_r    <= in_input ? digit : '0;
      if (!in_input) begin
        count_r <= '0;
        valid_r <= 1'b0;
      end else begin
        valid_r <= dec_rise && all_set;
        if (dec_rise && all_set) count_r <= digit;
      end
    end
  end

  assign bus.SEG       = seg_r;
  assign bus.SEG_Q     = seg_q_r;
  assign bus.COUNT_OUT = count_r;
  assign bus.ANS_VALID = valid_r;
  assign bus.QUE_OK    = que_ok_r;
  assign bus.LED       = led_r;

endmodule
